// File: rtl/rob_if.sv
// Shared ROB types and the allocation/CDB/commit/query bundle between the
// reorder buffer and its surrounding pipeline.
package rob_pkg;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_LEN = 3;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } cdb_data_t;

  typedef struct packed {
    logic                   valid;
    logic                   wr_mem;
    logic [4:0]             dest_reg;
    logic [XLEN-1:0]        value;
    logic                   value_ready;
    logic [XLEN-1:0]        dest_addr;
    logic                   address_ready;
    logic [ROB_TAG_LEN-1:0] store_dep;
  } rob_entry_t;
endpackage

interface rob_if;
  import rob_pkg::*;

  logic                   alloc_enable;
  logic                   alloc_wr_mem;
  logic [XLEN-1:0]        alloc_value_in;
  logic                   alloc_value_in_valid;
  logic [ROB_TAG_LEN-1:0] alloc_store_dep;
  logic [4:0]             dest_reg;
  cdb_data_t              cdb_data;
  logic [ROB_TAG_LEN-1:0] read_rob_tag;
  logic [XLEN-1:0]        load_address;
  logic [ROB_TAG_LEN-1:0] load_rob_tag;

  logic                   full;
  logic [ROB_TAG_LEN-1:0] alloc_slot;
  logic [XLEN-1:0]        read_value;
  logic                   pending_stores;
  rob_entry_t             head_entry;
  logic                   head_ready;
  rob_entry_t             rob0;
  rob_entry_t             rob1;
  rob_entry_t             rob2;
  rob_entry_t             rob3;

  modport master (
    output alloc_enable, alloc_wr_mem, alloc_value_in, alloc_value_in_valid,
    output alloc_store_dep, dest_reg, cdb_data, read_rob_tag, load_address,
    output load_rob_tag,
    input  full, alloc_slot, read_value, pending_stores, head_entry, head_ready,
    input  rob0, rob1, rob2, rob3
  );

  modport slave (
    input  alloc_enable, alloc_wr_mem, alloc_value_in, alloc_value_in_valid,
    input  alloc_store_dep, dest_reg, cdb_data, read_rob_tag, load_address,
    input  load_rob_tag,
    output full, alloc_slot, read_value, pending_stores, head_entry, head_ready,
    output rob0, rob1, rob2, rob3
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: circular entry store with in-order auto-commit, CDB snooping,
// store-value forwarding and a load-vs-older-store address check.
module rob
  import rob_pkg::*;
#(
  parameter int unsigned ROB_SIZE = 8
) (
  input logic   clock,
  input logic   reset,
  rob_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;

  rob_entry_t       entries_q [ROB_SIZE];
  rob_entry_t       entries_d [ROB_SIZE];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  cdb_data_t        cdb;
  rob_entry_t       head_e;
  rob_entry_t       new_entry;
  logic             full_c;
  logic             head_ready_c;
  logic             alloc_accept_c;
  logic [XLEN-1:0]  read_value_c;
  logic             pending_c;
  logic             scan_c;
  logic [PTR_W-1:0] scan_idx;

  assign cdb    = bus.cdb_data;
  assign head_e = entries_q[head_q];

  // Occupancy status and acceptance; a full ROB still accepts while the head retires.
  always_comb begin
    full_c         = (count_q == CNT_W'(ROB_SIZE));
    head_ready_c   = head_e.valid && head_e.value_ready &&
                     (!head_e.wr_mem || head_e.address_ready);
    alloc_accept_c = bus.alloc_enable && (!full_c || head_ready_c);
  end

  // Next state: CDB snoop first, then retire the head, then write the tail slot.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    new_entry = '0;

    if (cdb.valid) begin
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        if (entries_q[i].valid) begin
          if (entries_q[i].wr_mem) begin
            if (cdb.rob_tag == ROB_TAG_LEN'(i)) begin
              entries_d[i].dest_addr     = cdb.value;
              entries_d[i].address_ready = 1'b1;
            end
            if (!entries_q[i].value_ready && entries_q[i].store_dep == cdb.rob_tag) begin
              entries_d[i].value       = cdb.value;
              entries_d[i].value_ready = 1'b1;
            end
          end else if (cdb.rob_tag == ROB_TAG_LEN'(i)) begin
            entries_d[i].value       = cdb.value;
            entries_d[i].value_ready = 1'b1;
          end
        end
      end
    end

    if (head_ready_c) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_W'(1);
    end

    if (alloc_accept_c) begin
      new_entry.valid     = 1'b1;
      new_entry.wr_mem    = bus.alloc_wr_mem;
      new_entry.dest_reg  = bus.dest_reg;
      new_entry.store_dep = bus.alloc_store_dep;
      if (bus.alloc_value_in_valid) begin
        new_entry.value       = bus.alloc_value_in;
        new_entry.value_ready = 1'b1;
      end else if (bus.alloc_wr_mem && cdb.valid && cdb.rob_tag == bus.alloc_store_dep) begin
        new_entry.value       = cdb.value;
        new_entry.value_ready = 1'b1;
      end
      entries_d[tail_q] = new_entry;
      tail_d            = tail_q + PTR_W'(1);
    end

    case ({alloc_accept_c, head_ready_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Read port and the older-store scan from head up to (not including) the load.
  always_comb begin
    read_value_c = '0;
    pending_c    = 1'b0;
    scan_c       = 1'b1;
    scan_idx     = '0;
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      if (bus.read_rob_tag == ROB_TAG_LEN'(i)) begin
        read_value_c = entries_q[i].value;
      end
    end
    for (int k = 0; k < int'(ROB_SIZE); k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (ROB_TAG_LEN'(scan_idx) == bus.load_rob_tag) begin
        scan_c = 1'b0;
      end
      if (scan_c && entries_q[scan_idx].valid && entries_q[scan_idx].wr_mem &&
          entries_q[scan_idx].address_ready &&
          entries_q[scan_idx].dest_addr == bus.load_address) begin
        pending_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign bus.full           = full_c;
  assign bus.alloc_slot     = ROB_TAG_LEN'(tail_q);
  assign bus.read_value     = read_value_c;
  assign bus.pending_stores = pending_c;
  assign bus.head_entry     = head_e;
  assign bus.head_ready     = head_ready_c;
  assign bus.rob0           = entries_q[0];
  assign bus.rob1           = entries_q[1];
  assign bus.rob2           = entries_q[2];
  assign bus.rob3           = entries_q[3];

endmodule

// File: tb/tb_rob.sv
// Testbench for rob (4 entries): directed scenarios plus randomized traffic
// compared against a program-order queue model of the buffer.
module tb_rob;
  import rob_pkg::*;

  localparam int unsigned SIZE = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  rob_if bus ();

  rob #(.ROB_SIZE(SIZE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic clr_in();
    bus.alloc_enable         = 1'b0;
    bus.alloc_wr_mem         = 1'b0;
    bus.alloc_value_in       = '0;
    bus.alloc_value_in_valid = 1'b0;
    bus.alloc_store_dep      = '0;
    bus.dest_reg             = '0;
    bus.cdb_data             = '0;
    bus.read_rob_tag         = '0;
    bus.load_address         = '0;
    bus.load_rob_tag         = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alloc(input logic wr, input logic [4:0] dest, input logic [XLEN-1:0] val,
                           input logic vv, input logic [ROB_TAG_LEN-1:0] dep);
    bus.alloc_enable         = 1'b1;
    bus.alloc_wr_mem         = wr;
    bus.dest_reg             = dest;
    bus.alloc_value_in       = val;
    bus.alloc_value_in_valid = vv;
    bus.alloc_store_dep      = dep;
  endtask

  task automatic set_cdb(input logic [ROB_TAG_LEN-1:0] tag, input logic [XLEN-1:0] val);
    bus.cdb_data.valid   = 1'b1;
    bus.cdb_data.rob_tag = tag;
    bus.cdb_data.value   = val;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr_in();
    do_reset();
    #1;
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0d want 0", bus.full); end
    n_checks++; if (bus.alloc_slot !== 3'd0) begin n_fail++; $display("FAIL rst_slot: got %0d want 0", bus.alloc_slot); end
    n_checks++; if (bus.head_ready !== 1'b0) begin n_fail++; $display("FAIL rst_head_ready: got %0d want 0", bus.head_ready); end
    n_checks++; if (bus.pending_stores !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", bus.pending_stores); end
    n_checks++; if (bus.read_value !== '0) begin n_fail++; $display("FAIL rst_read: got %0h want 0", bus.read_value); end
    n_checks++; if (bus.head_entry !== '0) begin n_fail++; $display("FAIL rst_head_entry: got %0h want 0", bus.head_entry); end
    // Reset must win over allocation and CDB traffic on the same edge.
    set_alloc(1'b0, 5'd7, 32'd9, 1'b1, 3'd0);
    step();
    step();
    set_alloc(1'b1, 5'd8, 32'd3, 1'b0, 3'd0);
    set_cdb(3'd1, 32'd6);
    do_reset();
    clr_in();
    #1;
    n_checks++; if (bus.alloc_slot !== 3'd0) begin n_fail++; $display("FAIL rst_ovr_slot: got %0d want 0", bus.alloc_slot); end
    n_checks++; if (bus.rob0 !== '0 || bus.rob1 !== '0 || bus.rob2 !== '0)
      begin n_fail++; $display("FAIL rst_ovr_entries: got %0h/%0h/%0h want 0", bus.rob0, bus.rob1, bus.rob2); end
    n_checks++; if (bus.head_entry !== '0) begin n_fail++; $display("FAIL rst_ovr_head: got %0h want 0", bus.head_entry); end
  endtask

  task automatic test_basic_flow();
    clr_in();
    do_reset();
    set_alloc(1'b0, 5'd3, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.alloc_slot !== 3'd1) begin n_fail++; $display("FAIL basic_slot: got %0d want 1", bus.alloc_slot); end
    n_checks++; if (bus.head_ready !== 1'b0) begin n_fail++; $display("FAIL basic_not_ready: got %0d want 0", bus.head_ready); end
    n_checks++; if (bus.head_entry.valid !== 1'b1 || bus.head_entry.dest_reg !== 5'd3)
      begin n_fail++; $display("FAIL basic_head_dest: got v%0d d%0d want v1 d3", bus.head_entry.valid, bus.head_entry.dest_reg); end
    set_alloc(1'b0, 5'd4, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    set_cdb(3'd0, 32'd5);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b1 || bus.head_entry.value !== 32'd5)
      begin n_fail++; $display("FAIL basic_first_ready: got r%0d v%0d want r1 v5", bus.head_ready, bus.head_entry.value); end
    set_cdb(3'd1, 32'd11);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b1 || bus.head_entry.dest_reg !== 5'd4 || bus.head_entry.value !== 32'd11)
      begin n_fail++; $display("FAIL basic_second: got r%0d d%0d v%0d want r1 d4 v11",
                               bus.head_ready, bus.head_entry.dest_reg, bus.head_entry.value); end
    step();
    bus.read_rob_tag = 3'd0;
    #1;
    n_checks++; if (bus.head_entry.valid !== 1'b0 || bus.head_ready !== 1'b0)
      begin n_fail++; $display("FAIL basic_drained: got v%0d r%0d want v0 r0", bus.head_entry.valid, bus.head_ready); end
    n_checks++; if (bus.read_value !== 32'd5) begin n_fail++; $display("FAIL basic_read: got %0d want 5", bus.read_value); end
  endtask

  task automatic test_full();
    clr_in();
    do_reset();
    for (int d = 1; d <= 4; d++) begin
      set_alloc(1'b0, 5'(d), 32'd0, 1'b0, 3'd0);
      step();
    end
    clr_in();
    #1;
    n_checks++; if (bus.full !== 1'b1 || bus.alloc_slot !== 3'd0)
      begin n_fail++; $display("FAIL full_set: got f%0d s%0d want f1 s0", bus.full, bus.alloc_slot); end
    set_alloc(1'b0, 5'd9, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.full !== 1'b1 || bus.rob0.dest_reg !== 5'd1 || bus.alloc_slot !== 3'd0)
      begin n_fail++; $display("FAIL full_ignore: got f%0d d%0d s%0d want f1 d1 s0", bus.full, bus.rob0.dest_reg, bus.alloc_slot); end
    set_cdb(3'd0, 32'd7);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b1 || bus.full !== 1'b1)
      begin n_fail++; $display("FAIL full_head_ready: got r%0d f%0d want r1 f1", bus.head_ready, bus.full); end
    set_alloc(1'b0, 5'd5, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.full !== 1'b1 || bus.head_entry.dest_reg !== 5'd2 || bus.rob0.dest_reg !== 5'd5 || bus.alloc_slot !== 3'd1)
      begin n_fail++; $display("FAIL full_swap: got f%0d hd%0d r0d%0d s%0d want f1 hd2 r0d5 s1",
                               bus.full, bus.head_entry.dest_reg, bus.rob0.dest_reg, bus.alloc_slot); end
  endtask

  task automatic test_store_value();
    clr_in();
    do_reset();
    set_alloc(1'b1, 5'd0, 32'd10, 1'b1, 3'd0);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b0 || bus.head_entry.value !== 32'd10 || bus.head_entry.value_ready !== 1'b1)
      begin n_fail++; $display("FAIL store_issue: got r%0d v%0d vr%0d want r0 v10 vr1",
                               bus.head_ready, bus.head_entry.value, bus.head_entry.value_ready); end
    set_cdb(3'd0, 32'd11);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b1 || bus.head_entry.dest_addr !== 32'd11 || bus.head_entry.value !== 32'd10)
      begin n_fail++; $display("FAIL store_addr: got r%0d a%0d v%0d want r1 a11 v10",
                               bus.head_ready, bus.head_entry.dest_addr, bus.head_entry.value); end
  endtask

  task automatic test_forwarding();
    clr_in();
    do_reset();
    set_alloc(1'b0, 5'd5, 32'd0, 1'b0, 3'd0);
    step();
    set_alloc(1'b1, 5'd0, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.rob1.value_ready !== 1'b0) begin n_fail++; $display("FAIL fwd_wait: got %0d want 0", bus.rob1.value_ready); end
    set_alloc(1'b1, 5'd0, 32'd0, 1'b0, 3'd0);
    set_cdb(3'd0, 32'd5);
    step();
    clr_in();
    #1;
    n_checks++; if ({bus.rob1.value_ready, bus.rob1.value} !== {1'b1, 32'd5})
      begin n_fail++; $display("FAIL fwd_old_store: got vr%0d v%0d want vr1 v5", bus.rob1.value_ready, bus.rob1.value); end
    n_checks++; if ({bus.rob2.value_ready, bus.rob2.value} !== {1'b1, 32'd5})
      begin n_fail++; $display("FAIL fwd_same_cycle: got vr%0d v%0d want vr1 v5", bus.rob2.value_ready, bus.rob2.value); end
    step();
    #1;
    n_checks++; if (bus.head_ready !== 1'b0 || bus.head_entry.wr_mem !== 1'b1)
      begin n_fail++; $display("FAIL fwd_no_addr: got r%0d w%0d want r0 w1", bus.head_ready, bus.head_entry.wr_mem); end
    set_cdb(3'd1, 32'd9);
    step();
    clr_in();
    #1;
    n_checks++; if (bus.head_ready !== 1'b1 || bus.head_entry.dest_addr !== 32'd9)
      begin n_fail++; $display("FAIL fwd_addr: got r%0d a%0d want r1 a9", bus.head_ready, bus.head_entry.dest_addr); end
  endtask

  task automatic test_pending();
    clr_in();
    do_reset();
    set_alloc(1'b0, 5'd1, 32'd0, 1'b0, 3'd0);
    step();
    set_alloc(1'b1, 5'd0, 32'd77, 1'b1, 3'd0);
    step();
    set_alloc(1'b1, 5'd0, 32'd78, 1'b1, 3'd0);
    step();
    set_alloc(1'b0, 5'd2, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    bus.load_address = 32'd5;
    bus.load_rob_tag = 3'd3;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b0) begin n_fail++; $display("FAIL pend_unknown: got %0d want 0", bus.pending_stores); end
    set_cdb(3'd1, 32'd5);
    step();
    set_cdb(3'd2, 32'd5);
    step();
    bus.cdb_data = '0;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b1) begin n_fail++; $display("FAIL pend_match: got %0d want 1", bus.pending_stores); end
    bus.load_address = 32'd4;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b0) begin n_fail++; $display("FAIL pend_addr_diff: got %0d want 0", bus.pending_stores); end
    bus.load_address = 32'd5;
    bus.load_rob_tag = 3'd0;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b0) begin n_fail++; $display("FAIL pend_at_head: got %0d want 0", bus.pending_stores); end
    set_cdb(3'd0, 32'd1);
    step();
    clr_in();
    step();
    step();
    step();
    bus.load_address = 32'd5;
    bus.load_rob_tag = 3'd3;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b0 || bus.head_entry.dest_reg !== 5'd2)
      begin n_fail++; $display("FAIL pend_drained: got p%0d hd%0d want p0 hd2", bus.pending_stores, bus.head_entry.dest_reg); end
    // Wrapped scan: head at slot 2, load at slot 0.
    clr_in();
    do_reset();
    set_alloc(1'b0, 5'd1, 32'd1, 1'b1, 3'd0);
    step();
    set_alloc(1'b0, 5'd2, 32'd2, 1'b1, 3'd0);
    step();
    set_alloc(1'b1, 5'd0, 32'd3, 1'b1, 3'd0);
    step();
    set_alloc(1'b0, 5'd3, 32'd0, 1'b0, 3'd0);
    step();
    set_alloc(1'b0, 5'd4, 32'd0, 1'b0, 3'd0);
    step();
    clr_in();
    set_cdb(3'd2, 32'd4);
    step();
    clr_in();
    bus.load_address = 32'd4;
    bus.load_rob_tag = 3'd0;
    #1;
    n_checks++; if (bus.pending_stores !== 1'b1 || bus.head_entry.wr_mem !== 1'b1)
      begin n_fail++; $display("FAIL pend_wrap: got p%0d w%0d want p1 w1", bus.pending_stores, bus.head_entry.wr_mem); end
  endtask

  typedef struct {
    int         tag;
    rob_entry_t e;
  } m_t;

  task automatic test_random();
    m_t              mq[$];
    int              m_tail;
    logic [XLEN-1:0] slot_val [SIZE];
    rob_entry_t      exp_head;
    rob_entry_t      ne;
    logic            e_hr;
    logic            e_pend;
    logic            commit;
    int              ctag;

    clr_in();
    do_reset();
    mq.delete();
    m_tail = 0;
    for (int i = 0; i < int'(SIZE); i++) slot_val[i] = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset                    = ($urandom_range(0, 199) == 0);
      bus.alloc_enable         = ($urandom_range(0, 9) < 6);
      bus.alloc_wr_mem         = ($urandom_range(0, 9) < 4);
      bus.dest_reg             = 5'($urandom);
      bus.alloc_value_in       = XLEN'($urandom_range(0, 3));
      bus.alloc_value_in_valid = ($urandom_range(0, 9) < 4);
      bus.alloc_store_dep      = ROB_TAG_LEN'($urandom_range(0, SIZE - 1));
      bus.cdb_data.valid       = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ctag = $urandom_range(0, 7);
      bus.cdb_data.rob_tag     = ROB_TAG_LEN'(ctag);
      bus.cdb_data.value       = XLEN'($urandom_range(0, 3));
      bus.read_rob_tag         = ROB_TAG_LEN'($urandom_range(0, SIZE - 1));
      bus.load_address         = XLEN'($urandom_range(0, 3));
      bus.load_rob_tag         = ROB_TAG_LEN'($urandom_range(0, 7));
      #1;

      e_hr = (mq.size() > 0) && mq[0].e.value_ready && (!mq[0].e.wr_mem || mq[0].e.address_ready);
      e_pend = 1'b0;
      foreach (mq[i]) begin
        if (ROB_TAG_LEN'(mq[i].tag) == bus.load_rob_tag) break;
        if (mq[i].e.wr_mem && mq[i].e.address_ready && mq[i].e.dest_addr == bus.load_address) e_pend = 1'b1;
      end

      n_checks++; if (bus.full !== (mq.size() == int'(SIZE)))
        begin n_fail++; $display("FAIL rnd_full cyc%0d: got %0d want %0d", cyc, bus.full, mq.size() == int'(SIZE)); end
      n_checks++; if (bus.alloc_slot !== ROB_TAG_LEN'(m_tail))
        begin n_fail++; $display("FAIL rnd_slot cyc%0d: got %0d want %0d", cyc, bus.alloc_slot, m_tail); end
      n_checks++; if (bus.head_ready !== e_hr)
        begin n_fail++; $display("FAIL rnd_head_ready cyc%0d: got %0d want %0d", cyc, bus.head_ready, e_hr); end
      n_checks++; if (bus.pending_stores !== e_pend)
        begin n_fail++; $display("FAIL rnd_pending cyc%0d: got %0d want %0d", cyc, bus.pending_stores, e_pend); end
      n_checks++; if (bus.read_value !== slot_val[bus.read_rob_tag])
        begin n_fail++; $display("FAIL rnd_read cyc%0d: got %0h want %0h", cyc, bus.read_value, slot_val[bus.read_rob_tag]); end
      if (mq.size() > 0) begin
        exp_head = mq[0].e;
        n_checks++; if (bus.head_entry !== exp_head)
          begin n_fail++; $display("FAIL rnd_head cyc%0d: got %0h want %0h", cyc, bus.head_entry, exp_head); end
      end else begin
        n_checks++; if (bus.head_entry.valid !== 1'b0)
          begin n_fail++; $display("FAIL rnd_head_empty cyc%0d: got %0d want 0", cyc, bus.head_entry.valid); end
      end

      if (reset) begin
        mq.delete();
        m_tail = 0;
        for (int i = 0; i < int'(SIZE); i++) slot_val[i] = '0;
      end else begin
        commit = e_hr;
        if (bus.cdb_data.valid) begin
          foreach (mq[i]) begin
            if (ROB_TAG_LEN'(mq[i].tag) == bus.cdb_data.rob_tag) begin
              if (mq[i].e.wr_mem) begin
                mq[i].e.dest_addr     = bus.cdb_data.value;
                mq[i].e.address_ready = 1'b1;
              end else begin
                mq[i].e.value         = bus.cdb_data.value;
                mq[i].e.value_ready   = 1'b1;
                slot_val[mq[i].tag]   = bus.cdb_data.value;
              end
            end
            if (mq[i].e.wr_mem && !mq[i].e.value_ready && mq[i].e.store_dep == bus.cdb_data.rob_tag) begin
              mq[i].e.value       = bus.cdb_data.value;
              mq[i].e.value_ready = 1'b1;
              slot_val[mq[i].tag] = bus.cdb_data.value;
            end
          end
        end
        if (bus.alloc_enable && (mq.size() < int'(SIZE) || commit)) begin
          ne           = '0;
          ne.valid     = 1'b1;
          ne.wr_mem    = bus.alloc_wr_mem;
          ne.dest_reg  = bus.dest_reg;
          ne.store_dep = bus.alloc_store_dep;
          if (bus.alloc_value_in_valid) begin
            ne.value       = bus.alloc_value_in;
            ne.value_ready = 1'b1;
          end else if (bus.alloc_wr_mem && bus.cdb_data.valid && bus.cdb_data.rob_tag == bus.alloc_store_dep) begin
            ne.value       = bus.cdb_data.value;
            ne.value_ready = 1'b1;
          end
          if (commit) void'(mq.pop_front());
          commit = 1'b0;
          mq.push_back('{tag: m_tail, e: ne});
          slot_val[m_tail] = ne.value;
          m_tail = (m_tail + 1) % int'(SIZE);
        end
        if (commit) void'(mq.pop_front());
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_basic_flow();
    test_full();
    test_store_value();
    test_forwarding();
    test_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
